// File: rtl/rx_ctrl_pkg.sv
// Shared types and constants for the receive-chain PRI sequencer.
package rx_ctrl_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int FRM_W_DEF = 16;

  localparam logic [2:0] ADDR_PRI   = 3'd0;
  localparam logic [2:0] ADDR_TX    = 3'd1;
  localparam logic [2:0] ADDR_BLANK = 3'd2;
  localparam logic [2:0] ADDR_WIN   = 3'd3;
  localparam logic [2:0] ADDR_FLUSH = 3'd4;
  localparam logic [2:0] ADDR_NFRM  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_TX, S_BLANK, S_WINDOW, S_FLUSH, S_WAIT
  } state_t;
endpackage

// File: rtl/rx_cfg_regs.sv
// Shadow timing registers, active copy loaded at PRI start, and validity check on the shadows.
module rx_cfg_regs
  import rx_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int FRM_W = FRM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  input  logic             load,
  output logic [CNT_W-1:0] act_pri,
  output logic [CNT_W-1:0] act_tx,
  output logic [CNT_W-1:0] act_blank,
  output logic [CNT_W-1:0] act_win,
  output logic [CNT_W-1:0] act_flush,
  output logic [FRM_W-1:0] act_nfrm,
  output logic             sh_valid
);
  localparam int SW = CNT_W + 3;

  logic [CNT_W-1:0] sh_pri, sh_tx, sh_blank, sh_win, sh_flush;
  logic [FRM_W-1:0] sh_nfrm;
  logic [SW-1:0]    sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_pri <= '0; sh_tx <= '0; sh_blank <= '0;
      sh_win <= '0; sh_flush <= '0; sh_nfrm <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        ADDR_PRI:   sh_pri   <= cfg_wdata;
        ADDR_TX:    sh_tx    <= cfg_wdata;
        ADDR_BLANK: sh_blank <= cfg_wdata;
        ADDR_WIN:   sh_win   <= cfg_wdata;
        ADDR_FLUSH: sh_flush <= cfg_wdata;
        ADDR_NFRM:  sh_nfrm  <= cfg_wdata[FRM_W-1:0];
        default: ;
      endcase
    end
  end

  // Loading samples the pre-write shadow, so a coincident write lands in the next PRI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_pri <= '0; act_tx <= '0; act_blank <= '0;
      act_win <= '0; act_flush <= '0; act_nfrm <= '0;
    end else if (load) begin
      act_pri <= sh_pri; act_tx <= sh_tx; act_blank <= sh_blank;
      act_win <= sh_win; act_flush <= sh_flush; act_nfrm <= sh_nfrm;
    end
  end

  always_comb begin
    sum      = SW'(sh_tx) + SW'(sh_blank) + SW'(sh_win) + SW'(sh_flush);
    sh_valid = (sh_tx != '0) && (sh_win != '0) && (sum <= SW'(sh_pri));
  end
endmodule

// File: rtl/rx_pri_sequencer.sv
// PRI frame-timing FSM: sequences TX/blank/window/flush/wait and drives receive-chain gates.
module rx_pri_sequencer
  import rx_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int FRM_W = FRM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  input  logic             start,
  input  logic             stop,
  output logic             tx_gate,
  output logic             adc_en,
  output logic             win_gate,
  output logic             pc_start,
  output logic [CNT_W-1:0] sample_idx,
  output logic             frame_done,
  output logic [FRM_W-1:0] frame_cnt,
  output logic             busy,
  output logic             cfg_err
);
  logic [CNT_W-1:0] a_pri, a_tx, a_blank, a_win, a_flush;
  logic [FRM_W-1:0] a_nfrm;
  logic             load, sh_valid, set_err, accept, pri_last, lim, nxt_fd, stop_pend;
  state_t           state, nxt_state;
  logic [CNT_W-1:0] ph_cnt, nxt_ph, pri_cnt, nxt_pri;

  rx_cfg_regs #(.CNT_W(CNT_W), .FRM_W(FRM_W)) u_cfg (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .load(load), .act_pri(a_pri), .act_tx(a_tx), .act_blank(a_blank), .act_win(a_win),
    .act_flush(a_flush), .act_nfrm(a_nfrm), .sh_valid(sh_valid)
  );

  // End of PRI overrides phase transitions so a zero-length WAIT needs no special case.
  always_comb begin
    nxt_state = state;
    nxt_ph    = ph_cnt + CNT_W'(1);
    nxt_pri   = pri_cnt + CNT_W'(1);
    load      = 1'b0;
    set_err   = 1'b0;
    accept    = 1'b0;
    pri_last  = (pri_cnt == a_pri - CNT_W'(1));
    lim       = (a_nfrm != '0) && (frame_cnt == a_nfrm);
    if (state == S_IDLE) begin
      nxt_ph  = '0;
      nxt_pri = '0;
      if (start) begin
        if (sh_valid) begin
          nxt_state = S_TX; load = 1'b1; accept = 1'b1;
        end else set_err = 1'b1;
      end
    end else if (pri_last) begin
      nxt_ph  = '0;
      nxt_pri = '0;
      if (stop_pend || stop || lim) nxt_state = S_IDLE;
      else if (sh_valid) begin
        nxt_state = S_TX; load = 1'b1;
      end else begin
        nxt_state = S_IDLE; set_err = 1'b1;
      end
    end else begin
      case (state)
        S_TX:     if (ph_cnt == a_tx - CNT_W'(1)) begin
                    nxt_ph = '0; nxt_state = (a_blank != '0) ? S_BLANK : S_WINDOW;
                  end
        S_BLANK:  if (ph_cnt == a_blank - CNT_W'(1)) begin
                    nxt_ph = '0; nxt_state = S_WINDOW;
                  end
        S_WINDOW: if (ph_cnt == a_win - CNT_W'(1)) begin
                    nxt_ph = '0; nxt_state = (a_flush != '0) ? S_FLUSH : S_WAIT;
                  end
        S_FLUSH:  if (ph_cnt == a_flush - CNT_W'(1)) begin
                    nxt_ph = '0; nxt_state = S_WAIT;
                  end
        default: ;
      endcase
    end
    nxt_fd = ((nxt_state == S_FLUSH) && (nxt_ph == a_flush - CNT_W'(1))) ||
             ((nxt_state == S_WINDOW) && (a_flush == '0) && (nxt_ph == a_win - CNT_W'(1)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE; ph_cnt <= '0; pri_cnt <= '0; stop_pend <= 1'b0;
      tx_gate <= 1'b0; adc_en <= 1'b0; win_gate <= 1'b0; pc_start <= 1'b0;
      sample_idx <= '0; frame_done <= 1'b0; frame_cnt <= '0; busy <= 1'b0; cfg_err <= 1'b0;
    end else begin
      state      <= nxt_state;
      ph_cnt     <= nxt_ph;
      pri_cnt    <= nxt_pri;
      tx_gate    <= (nxt_state == S_TX);
      adc_en     <= (nxt_state != S_IDLE);
      busy       <= (nxt_state != S_IDLE);
      win_gate   <= (nxt_state == S_WINDOW);
      pc_start   <= (nxt_state == S_WINDOW) && (nxt_ph == '0);
      sample_idx <= (nxt_state == S_WINDOW) ? nxt_ph : '0;
      frame_done <= nxt_fd;
      if (accept)      frame_cnt <= '0;
      else if (nxt_fd) frame_cnt <= frame_cnt + FRM_W'(1);
      if (accept)       cfg_err <= 1'b0;
      else if (set_err) cfg_err <= 1'b1;
      if (nxt_state == S_IDLE)           stop_pend <= 1'b0;
      else if (stop && state != S_IDLE)  stop_pend <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rx_pri_sequencer.sv
// Directed bench for rx_pri_sequencer: frame timing, config rejection, stop, live reconfig, reset.
module tb_rx_pri_sequencer;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cfg_we = 1'b0, start = 1'b0, stop = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic        tx_gate, adc_en, win_gate, pc_start, frame_done, busy, cfg_err;
  logic [15:0] sample_idx, frame_cnt;
  logic [5:0]  obs_bits, eb;
  int          checks = 0, errors = 0;

  rx_pri_sequencer #(.CNT_W(16), .FRM_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .stop(stop), .tx_gate(tx_gate), .adc_en(adc_en), .win_gate(win_gate),
    .pc_start(pc_start), .sample_idx(sample_idx), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  assign obs_bits = {tx_gate, adc_en, win_gate, pc_start, frame_done, busy};

  // Expected {tx_gate, adc_en, win_gate, pc_start, frame_done, busy} at cycle k after start (cycle 0).
  function automatic logic [5:0] exp_bits(input int k, pri, tx, bl, w0, w1, fl, npri);
    int p, off, w, ws;
    if (k < 1) return 6'b0;
    p = (k - 1) / pri; off = (k - 1) % pri;
    if (p >= npri) return 6'b0;
    w = (p == 0) ? w0 : w1; ws = tx + bl;
    return {off < tx, 1'b1, (off >= ws) && (off < ws + w), off == ws,
            off == ws + w + fl - 1, 1'b1};
  endfunction

  function automatic int exp_idx(input int k, pri, tx, bl);
    return (k - 1) % pri - (tx + bl);
  endfunction

  task automatic wr(input logic [2:0] a, input int d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = 16'(d);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic cfg_all(input int pri, tx, bl, win, fl, nf);
    wr(3'd0, pri); wr(3'd1, tx); wr(3'd2, bl); wr(3'd3, win); wr(3'd4, fl); wr(3'd5, nf);
  endtask

  task automatic test_reset;
    checks++;
    if ({obs_bits, sample_idx, frame_cnt, cfg_err} !== '0)
      begin errors++; $display("FAIL reset got %b/%0d/%0d/%b exp 0", obs_bits, sample_idx, frame_cnt, cfg_err); end
  endtask

  task automatic test_basic;
    cfg_all(20, 2, 3, 8, 4, 2);
    start = 1'b1;
    for (int k = 1; k <= 44; k++) begin
      @(posedge clk); #1; start = 1'b0;
      eb = exp_bits(k, 20, 2, 3, 8, 8, 4, 2);
      checks++;
      if (obs_bits !== eb) begin errors++; $display("FAIL basic k=%0d got %b exp %b", k, obs_bits, eb); end
      if (eb[3]) begin
        checks++;
        if (sample_idx !== 16'(exp_idx(k, 20, 2, 3)))
          begin errors++; $display("FAIL basic_idx k=%0d got %0d exp %0d", k, sample_idx, exp_idx(k, 20, 2, 3)); end
      end
    end
    checks++;
    if (frame_cnt !== 16'd2) begin errors++; $display("FAIL basic_fcnt got %0d exp 2", frame_cnt); end
  endtask

  task automatic test_bad_cfg;
    cfg_all(16, 2, 3, 8, 4, 2);
    start = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1; start = 1'b0;
      checks++;
      if ({cfg_err, busy, tx_gate} !== 3'b100)
        begin errors++; $display("FAIL reject k=%0d got %b exp 100", k, {cfg_err, busy, tx_gate}); end
    end
    wr(3'd0, 17);
    start = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      @(posedge clk); #1; start = 1'b0;
      eb = exp_bits(k, 17, 2, 3, 8, 8, 4, 2);
      checks++;
      if (obs_bits !== eb) begin errors++; $display("FAIL nowait k=%0d got %b exp %b", k, obs_bits, eb); end
      if (k == 1) begin
        checks++;
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", cfg_err); end
      end
    end
    checks++;
    if (frame_cnt !== 16'd2) begin errors++; $display("FAIL nowait_fcnt got %0d exp 2", frame_cnt); end
  endtask

  task automatic test_no_blank_flush;
    cfg_all(10, 2, 0, 4, 0, 1);
    start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1; start = 1'b0;
      eb = exp_bits(k, 10, 2, 0, 4, 4, 0, 1);
      checks++;
      if (obs_bits !== eb) begin errors++; $display("FAIL nbf k=%0d got %b exp %b", k, obs_bits, eb); end
      if (k == 6) begin
        checks++;
        if ({frame_done, sample_idx} !== {1'b1, 16'd3})
          begin errors++; $display("FAIL nbf_done got fd=%b idx=%0d exp fd=1 idx=3", frame_done, sample_idx); end
      end
    end
  endtask

  task automatic test_stop;
    cfg_all(20, 2, 3, 8, 4, 0);
    start = 1'b1;
    for (int k = 1; k <= 44; k++) begin
      @(posedge clk); #1; start = 1'b0; stop = 1'b0;
      eb = exp_bits(k, 20, 2, 3, 8, 8, 4, 2);
      checks++;
      if (obs_bits !== eb) begin errors++; $display("FAIL stop k=%0d got %b exp %b", k, obs_bits, eb); end
      if (k == 25) stop = 1'b1;
    end
    checks++;
    if (frame_cnt !== 16'd2) begin errors++; $display("FAIL stop_fcnt got %0d exp 2", frame_cnt); end
  endtask

  task automatic test_cfg_change;
    cfg_all(20, 2, 3, 8, 4, 2);
    start = 1'b1;
    for (int k = 1; k <= 44; k++) begin
      @(posedge clk); #1; start = 1'b0; cfg_we = 1'b0;
      eb = exp_bits(k, 20, 2, 3, 8, 4, 4, 2);
      checks++;
      if (obs_bits !== eb) begin errors++; $display("FAIL recfg k=%0d got %b exp %b", k, obs_bits, eb); end
      if (k == 8) begin cfg_we = 1'b1; cfg_addr = 3'd3; cfg_wdata = 16'd4; end
    end
    checks++;
    if (frame_cnt !== 16'd2) begin errors++; $display("FAIL recfg_fcnt got %0d exp 2", frame_cnt); end
  endtask

  task automatic test_reset_mid;
    cfg_all(20, 2, 3, 8, 4, 2);
    start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1; start = 1'b0;
    end
    checks++;
    if (win_gate !== 1'b1) begin errors++; $display("FAIL rmid_pre got win=%b exp 1", win_gate); end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({obs_bits, sample_idx, frame_cnt, cfg_err} !== '0)
      begin errors++; $display("FAIL rmid_async got %b/%0d/%0d exp 0", obs_bits, sample_idx, frame_cnt); end
    @(posedge clk); #1 rst = 1'b0;
    test_basic();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_basic();
    test_bad_cfg();
    test_no_blank_flush();
    test_stop();
    test_cfg_change();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
